// File: rtl/mux_rr_n_pkg.sv
// Shared definitions for the registered N-channel valid/ready multiplexer.
// Mode encodings and the select-width helper used by the top and the arbiter.
package mux_rr_n_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // One bit minimum so a 2-channel mux still has a select/channel field.
   function automatic int unsigned calc_selw(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_rr_n_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
// The pointer register itself lives in the parent.
module rr_arbiter
   import mux_rr_n_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned SELW = calc_selw(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] gidx
);

   logic              found;
   int unsigned       idx;
   logic [SELW-1:0]   idx_s;

   always_comb begin
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      idx   = 0;
      idx_s = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= N) idx = idx - N;
         idx_s = SELW'(idx);
         if (!found && req[idx_s]) begin
            grant[idx_s] = 1'b1;
            gidx         = idx_s;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_n.sv
// Registered N:1 valid/ready multiplexer with fixed-select and round-robin modes.
// One output register stage; simultaneous drain and load gives full throughput.
module mux_rr_n
   import mux_rr_n_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned SELW = calc_selw(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mode,
   input  logic [SELW-1:0]    sel,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_chan,
   output logic               sel_err
);

   logic [SELW-1:0]  rr_ptr;
   logic [N-1:0]     grant_rr;
   logic [SELW-1:0]  gidx_rr;
   logic [N-1:0]     grant_fix;
   logic [N-1:0]     grant;
   logic [SELW-1:0]  gidx;
   logic             sel_bad;
   logic             space;
   logic             load;
   logic [WIDTH-1:0] sel_data;

   rr_arbiter #(
      .N (N)
   ) u_arb (
      .req   (in_valid),
      .ptr   (rr_ptr),
      .grant (grant_rr),
      .gidx  (gidx_rr)
   );

   // Fixed grant ignores in_valid; an out-of-range sel grants nobody.
   always_comb begin
      grant_fix = '0;
      sel_bad   = (32'(sel) >= N);
      if (!sel_bad) grant_fix[sel] = 1'b1;
   end

   always_comb begin
      grant = (mode == MODE_RR) ? grant_rr : grant_fix;
      gidx  = (mode == MODE_RR) ? gidx_rr  : sel;
   end

   assign space    = !out_valid || out_ready;
   assign in_ready = grant & {N{space}};
   assign load     = (|(grant & in_valid)) && space;

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_chan  <= gidx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Pointer only advances on a round-robin transfer; fixed mode leaves it alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (load && (mode == MODE_RR)) begin
         rr_ptr <= (gidx == SELW'(N - 1)) ? '0 : gidx + SELW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_err <= 1'b0;
      end else begin
         sel_err <= (mode == MODE_FIXED) && sel_bad;
      end
   end

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n: a 4-channel instance for the main function and a
// 3-channel instance for the out-of-range select pulse.
module tb_mux_rr_n;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 4-channel, 8-bit instance
   logic        mode4;
   logic [1:0]  sel4;
   logic [3:0]  in_valid4;
   logic [31:0] in_data4;
   logic [3:0]  in_ready4;
   logic        out_valid4;
   logic        out_ready4;
   logic [7:0]  out_data4;
   logic [1:0]  out_chan4;
   logic        sel_err4;

   // 3-channel, 8-bit instance
   logic        mode3;
   logic [1:0]  sel3;
   logic [2:0]  in_valid3;
   logic [23:0] in_data3;
   logic [2:0]  in_ready3;
   logic        out_valid3;
   logic        out_ready3;
   logic [7:0]  out_data3;
   logic [1:0]  out_chan3;
   logic        sel_err3;

   int n_checks = 0;
   int n_fail   = 0;

   mux_rr_n #(.N(4), .WIDTH(8)) u_dut4 (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode4),
      .sel       (sel4),
      .in_valid  (in_valid4),
      .in_data   (in_data4),
      .in_ready  (in_ready4),
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .out_data  (out_data4),
      .out_chan  (out_chan4),
      .sel_err   (sel_err4)
   );

   mux_rr_n #(.N(3), .WIDTH(8)) u_dut3 (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode3),
      .sel       (sel3),
      .in_valid  (in_valid3),
      .in_data   (in_data3),
      .in_ready  (in_ready3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .out_data  (out_data3),
      .out_chan  (out_chan3),
      .sel_err   (sel_err3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle 1 ns past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out4(input string tag, input logic v, input logic [7:0] d,
                             input logic [1:0] c, input logic [3:0] r);
      check({tag, ".valid"}, 32'(out_valid4), 32'(v));
      check({tag, ".data"},  32'(out_data4),  32'(d));
      check({tag, ".chan"},  32'(out_chan4),  32'(c));
      check({tag, ".ready"}, 32'(in_ready4),  32'(r));
   endtask

   initial begin
      reset      = 1'b1;
      mode4      = 1'b0;
      sel4       = 2'd0;
      in_valid4  = 4'b0000;
      in_data4   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      out_ready4 = 1'b0;
      mode3      = 1'b0;
      sel3       = 2'd0;
      in_valid3  = 3'b000;
      in_data3   = {8'hB2, 8'hB1, 8'hB0};
      out_ready3 = 1'b0;

      step();
      check("rst.valid4", 32'(out_valid4), 32'd0);
      check("rst.data4",  32'(out_data4),  32'd0);
      check("rst.chan4",  32'(out_chan4),  32'd0);
      check("rst.err4",   32'(sel_err4),   32'd0);
      check("rst.valid3", 32'(out_valid3), 32'd0);
      step();
      reset = 1'b0;

      // Fixed select of channel 2 with every channel requesting
      mode4      = 1'b0;
      sel4       = 2'd2;
      in_valid4  = 4'b1111;
      out_ready4 = 1'b1;
      #1;
      check("fix.ready_pre", 32'(in_ready4), 32'b0100);
      step();
      check_out4("fix", 1'b1, 8'hA2, 2'd2, 4'b0100);

      // Reset mid-transfer clears the output without a clock edge
      #1;
      reset = 1'b1;
      #1;
      check("arst.valid", 32'(out_valid4), 32'd0);
      check("arst.data",  32'(out_data4),  32'd0);
      check("arst.chan",  32'(out_chan4),  32'd0);
      step();
      reset = 1'b0;

      // Round-robin over requesters 0,1,3 starting from pointer 0
      mode4     = 1'b1;
      in_valid4 = 4'b1011;
      #1;
      check("rr.ready_pre", 32'(in_ready4), 32'b0001);
      step(); check_out4("rr0", 1'b1, 8'hA0, 2'd0, 4'b0010);
      step(); check_out4("rr1", 1'b1, 8'hA1, 2'd1, 4'b1000);
      step(); check_out4("rr2", 1'b1, 8'hA3, 2'd3, 4'b0001);
      step(); check_out4("rr3", 1'b1, 8'hA0, 2'd0, 4'b0010);
      step(); check_out4("rr4", 1'b1, 8'hA1, 2'd1, 4'b1000);
      step(); check_out4("rr5", 1'b1, 8'hA3, 2'd3, 4'b0001);

      // Backpressure: hold channel 3's word for 5 clocks, then load with no bubble
      out_ready4 = 1'b0;
      #1;
      check("bp.ready_pre", 32'(in_ready4), 32'b0000);
      for (int i = 0; i < 5; i++) begin
         step();
         check_out4($sformatf("bp%0d", i), 1'b1, 8'hA3, 2'd3, 4'b0000);
      end
      out_ready4 = 1'b1;
      #1;
      check("bp.ready_rel", 32'(in_ready4), 32'b0001);
      step();
      check_out4("bp.resume", 1'b1, 8'hA0, 2'd0, 4'b0010);

      // Mode switch: move pointer to 2, two fixed loads, back to RR resumes at 2
      in_valid4 = 4'b1111;
      step();
      check_out4("ms.rr", 1'b1, 8'hA1, 2'd1, 4'b0100);
      mode4 = 1'b0;
      sel4  = 2'd0;
      #1;
      check("ms.fix_ready", 32'(in_ready4), 32'b0001);
      step(); check_out4("ms.fix0", 1'b1, 8'hA0, 2'd0, 4'b0001);
      step(); check_out4("ms.fix1", 1'b1, 8'hA0, 2'd0, 4'b0001);
      mode4 = 1'b1;
      #1;
      check("ms.rr_ready", 32'(in_ready4), 32'b0100);
      step();
      check_out4("ms.rr_back", 1'b1, 8'hA2, 2'd2, 4'b1000);

      // No requests in RR mode: nothing granted, output drains
      in_valid4 = 4'b0000;
      #1;
      check("idle.ready", 32'(in_ready4), 32'b0000);
      step();
      check("idle.valid", 32'(out_valid4), 32'd0);

      // Fixed mode with the selected channel idle: no load, others starve
      mode4     = 1'b0;
      sel4      = 2'd1;
      in_valid4 = 4'b1101;
      step();
      check("starve.valid", 32'(out_valid4), 32'd0);
      check("starve.ready", 32'(in_ready4),  32'b0010);
      check("nopow.err4",   32'(sel_err4),   32'd0);

      // 3-channel: out-of-range select produces a one-cycle error pulse
      mode3      = 1'b0;
      sel3       = 2'd1;
      in_valid3  = 3'b111;
      out_ready3 = 1'b1;
      step();
      check("n3.valid", 32'(out_valid3), 32'd1);
      check("n3.data",  32'(out_data3),  32'hB1);
      check("n3.chan",  32'(out_chan3),  32'd1);
      out_ready3 = 1'b0;
      sel3       = 2'd3;
      #1;
      check("err.ready_pre", 32'(in_ready3), 32'b000);
      check("err.pre",       32'(sel_err3),  32'd0);
      step();
      check("err.pulse", 32'(sel_err3),   32'd1);
      check("err.valid", 32'(out_valid3), 32'd1);
      check("err.chan",  32'(out_chan3),  32'd1);
      check("err.ready", 32'(in_ready3),  32'b000);
      sel3 = 2'd0;
      step();
      check("err.clear", 32'(sel_err3),   32'd0);
      check("err.hold",  32'(out_valid3), 32'd1);
      check("err.data",  32'(out_data3),  32'hB1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
